// File: rtl/mem_arbiter.sv
// Two-requester DRAM arbiter: round-robin grant between the core (0) and the
// DMA/debug port (1), fixed MEM_LAT-cycle access, one-cycle Ack on completion.
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int DW      = 16,
    parameter int AW      = 16
) (
    input  logic          Clk1,
    input  logic          Reset,
    input  logic [AW-1:0] Req0Addr,
    input  logic          Req0RD,
    input  logic          Req0WR,
    input  logic [DW-1:0] Req0DataOut,
    output logic [DW-1:0] Req0DataIn,
    output logic          Req0Ack,
    input  logic [AW-1:0] Req1Addr,
    input  logic          Req1RD,
    input  logic          Req1WR,
    input  logic [DW-1:0] Req1DataOut,
    output logic [DW-1:0] Req1DataIn,
    output logic          Req1Ack,
    output logic [AW-1:0] MemAddr,
    output logic          MemRD,
    output logic          MemWR,
    output logic [DW-1:0] MemDataOut,
    input  logic [DW-1:0] MemDataIn,
    output logic          Busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       last_gnt;
    logic       gnt;
    logic       op_wr;

    logic       pend0;
    logic       pend1;
    logic       win1;
    logic       win_wr;

    assign pend0  = Req0RD | Req0WR;
    assign pend1  = Req1RD | Req1WR;
    // On a tie the requester not granted most recently wins.
    assign win1   = pend1 & (~pend0 | ~last_gnt);
    // WR dominates RD when a requester raises both.
    assign win_wr = win1 ? Req1WR : Req0WR;

    assign Busy = (state != IDLE);

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_gnt   <= 1'b1;
            gnt        <= 1'b0;
            op_wr      <= 1'b0;
            MemAddr    <= '0;
            MemDataOut <= '0;
            MemRD      <= 1'b0;
            MemWR      <= 1'b0;
            Req0Ack    <= 1'b0;
            Req1Ack    <= 1'b0;
            Req0DataIn <= '0;
            Req1DataIn <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend0 | pend1) begin
                        state      <= ACCESS;
                        gnt        <= win1;
                        last_gnt   <= win1;
                        op_wr      <= win_wr;
                        MemAddr    <= win1 ? Req1Addr : Req0Addr;
                        MemDataOut <= win1 ? Req1DataOut : Req0DataOut;
                        MemRD      <= ~win_wr;
                        MemWR      <= win_wr;
                        cnt        <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        MemRD <= 1'b0;
                        MemWR <= 1'b0;
                        if (gnt) Req1Ack <= 1'b1;
                        else     Req0Ack <= 1'b1;
                        if (!op_wr) begin
                            if (gnt) Req1DataIn <= MemDataIn;
                            else     Req0DataIn <= MemDataIn;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    Req0Ack <= 1'b0;
                    Req1Ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued at drive
// time and retired by a negedge monitor when an Ack appears.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int DW  = 16;
    localparam int AW  = 16;

    logic          Clk1 = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] Req0Addr = '0, Req1Addr = '0;
    logic          Req0RD = 1'b0, Req0WR = 1'b0, Req1RD = 1'b0, Req1WR = 1'b0;
    logic [DW-1:0] Req0DataOut = '0, Req1DataOut = '0;
    logic [DW-1:0] Req0DataIn, Req1DataIn;
    logic          Req0Ack, Req1Ack;
    logic [AW-1:0] MemAddr;
    logic          MemRD, MemWR, Busy;
    logic [DW-1:0] MemDataOut, MemDataIn;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit            id;
        bit            wr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    mem_arbiter #(.MEM_LAT(LAT), .DW(DW), .AW(AW)) dut (
        .Clk1(Clk1), .Reset(Reset),
        .Req0Addr(Req0Addr), .Req0RD(Req0RD), .Req0WR(Req0WR),
        .Req0DataOut(Req0DataOut), .Req0DataIn(Req0DataIn), .Req0Ack(Req0Ack),
        .Req1Addr(Req1Addr), .Req1RD(Req1RD), .Req1WR(Req1WR),
        .Req1DataOut(Req1DataOut), .Req1DataIn(Req1DataIn), .Req1Ack(Req1Ack),
        .MemAddr(MemAddr), .MemRD(MemRD), .MemWR(MemWR),
        .MemDataOut(MemDataOut), .MemDataIn(MemDataIn), .Busy(Busy)
    );

    always #5 Clk1 = ~Clk1;

    // DRAM model: fixed preload contents, overlaid by anything written.
    bit            written [0:255];
    logic [DW-1:0] dram    [0:255];

    function automatic logic [DW-1:0] preload(input logic [7:0] a);
        case (a)
            8'h10:   return 16'hBEEF;
            8'h40:   return 16'hC2C2;
            8'h50:   return 16'hA0A0;
            8'h60:   return 16'hB1B1;
            default: return {8'h5A, a};
        endcase
    endfunction

    function automatic logic [DW-1:0] dram_val(input logic [7:0] a);
        return written[a] ? dram[a] : preload(a);
    endfunction

    assign MemDataIn = dram_val(MemAddr[7:0]);

    always @(posedge Clk1) begin
        if (MemWR) begin
            dram[MemAddr[7:0]]    <= MemDataOut;
            written[MemAddr[7:0]] <= 1'b1;
        end
    end

    // Protocol monitor and scoreboard retirement.
    logic [AW-1:0] prev_addr;
    bit            prev_strobe = 1'b0;
    exp_t          mon_e;
    logic [DW-1:0] mon_din;

    always @(negedge Clk1) begin
        if (!Reset) begin
            n_checks++;
            if (Req0Ack && Req1Ack) begin
                n_fail++;
                $display("FAIL ack_onehot: Req0Ack=%b Req1Ack=%b, required at most one high", Req0Ack, Req1Ack);
            end
            n_checks++;
            if (MemRD && MemWR) begin
                n_fail++;
                $display("FAIL strobe_onehot: MemRD=%b MemWR=%b, required at most one high", MemRD, MemWR);
            end
            if (Busy && !Req0Ack && !Req1Ack) begin
                n_checks++;
                if (MemRD === MemWR) begin
                    n_fail++;
                    $display("FAIL access_strobe: MemRD=%b MemWR=%b, required exactly one high", MemRD, MemWR);
                end
            end
            if ((MemRD || MemWR) && prev_strobe) begin
                n_checks++;
                if (MemAddr !== prev_addr) begin
                    n_fail++;
                    $display("FAIL addr_stable: MemAddr=%h, required %h", MemAddr, prev_addr);
                end
            end
            if (Req0Ack || Req1Ack) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack: Req0Ack=%b Req1Ack=%b, required no Ack", Req0Ack, Req1Ack);
                end else begin
                    mon_e = sb.pop_front();
                    if (Req1Ack !== mon_e.id) begin
                        n_fail++;
                        $display("FAIL ack_owner: Req1Ack=%b, required requester %0d", Req1Ack, mon_e.id);
                    end
                    if (!mon_e.wr) begin
                        mon_din = mon_e.id ? Req1DataIn : Req0DataIn;
                        n_checks++;
                        if (mon_din !== mon_e.data) begin
                            n_fail++;
                            $display("FAIL read_data: req%0d DataIn=%h, required %h", mon_e.id, mon_din, mon_e.data);
                        end
                    end
                end
            end
        end
        prev_strobe = MemRD || MemWR;
        prev_addr   = MemAddr;
    end

    task automatic tick();
        @(posedge Clk1);
        #1;
    endtask

    task automatic clear_reqs();
        Req0RD = 1'b0; Req0WR = 1'b0;
        Req1RD = 1'b0; Req1WR = 1'b0;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        Req0RD = 1'b1;
        Req1WR = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({MemRD, MemWR, Req0Ack, Req1Ack, Busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: {RD,WR,Ack0,Ack1,Busy}=%b, required 00000",
                     {MemRD, MemWR, Req0Ack, Req1Ack, Busy});
        end
        n_checks++;
        if (MemAddr !== '0 || MemDataOut !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: MemAddr=%h MemDataOut=%h, required 0", MemAddr, MemDataOut);
        end
        n_checks++;
        if (Req0DataIn !== '0 || Req1DataIn !== '0) begin
            n_fail++;
            $display("FAIL reset_datain: Req0DataIn=%h Req1DataIn=%h, required 0", Req0DataIn, Req1DataIn);
        end
        clear_reqs();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        Req0Addr = 16'h0010;
        Req0RD   = 1'b1;
        sb.push_back('{id: 1'b0, wr: 1'b0, data: 16'hBEEF});
        for (int c = 1; c <= LAT; c++) begin
            tick();
            n_checks++;
            if (MemRD !== 1'b1 || MemWR !== 1'b0 || MemAddr !== 16'h0010 || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL read_access c%0d: RD=%b WR=%b Addr=%h Busy=%b, required 1 0 0010 1",
                         c, MemRD, MemWR, MemAddr, Busy);
            end
        end
        tick();
        n_checks++;
        if (Req0Ack !== 1'b1 || Req1Ack !== 1'b0 || MemRD !== 1'b0 || Req0DataIn !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL read_done: Ack0=%b Ack1=%b RD=%b DataIn=%h, required 1 0 0 beef",
                     Req0Ack, Req1Ack, MemRD, Req0DataIn);
        end
        clear_reqs();
        tick();
        n_checks++;
        if (Busy !== 1'b0 || Req0Ack !== 1'b0 || MemAddr !== 16'h0010) begin
            n_fail++;
            $display("FAIL read_idle: Busy=%b Ack0=%b Addr=%h, required 0 0 0010", Busy, Req0Ack, MemAddr);
        end
    endtask

    task automatic test_single_write();
        Req1Addr    = 16'h0020;
        Req1DataOut = 16'h1234;
        Req1WR      = 1'b1;
        sb.push_back('{id: 1'b1, wr: 1'b1, data: 16'h0000});
        for (int c = 1; c <= LAT; c++) begin
            tick();
            n_checks++;
            if (MemWR !== 1'b1 || MemRD !== 1'b0 || MemAddr !== 16'h0020 || MemDataOut !== 16'h1234) begin
                n_fail++;
                $display("FAIL write_access c%0d: WR=%b RD=%b Addr=%h Data=%h, required 1 0 0020 1234",
                         c, MemWR, MemRD, MemAddr, MemDataOut);
            end
        end
        tick();
        n_checks++;
        if (Req1Ack !== 1'b1 || Req0Ack !== 1'b0 || MemWR !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: Ack1=%b Ack0=%b WR=%b, required 1 0 0", Req1Ack, Req0Ack, MemWR);
        end
        clear_reqs();
        tick();
        n_checks++;
        if (dram_val(8'h20) !== 16'h1234) begin
            n_fail++;
            $display("FAIL write_dram: DRAM[0020]=%h, required 1234", dram_val(8'h20));
        end
    endtask

    task automatic test_tie();
        apply_reset();
        Req0Addr = 16'h0050;
        Req1Addr = 16'h0060;
        Req0RD   = 1'b1;
        Req1RD   = 1'b1;
        for (int k = 0; k < 4; k++)
            sb.push_back('{id: bit'(k % 2), wr: 1'b0, data: (k % 2 == 0) ? 16'hA0A0 : 16'hB1B1});
        for (int cyc = 1; cyc <= 4 * (LAT + 2); cyc++) begin
            logic e0, e1;
            tick();
            e0 = (cyc % (LAT + 2) == LAT + 1) && ((cyc / (LAT + 2)) % 2 == 0);
            e1 = (cyc % (LAT + 2) == LAT + 1) && ((cyc / (LAT + 2)) % 2 == 1);
            n_checks++;
            if (Req0Ack !== e0 || Req1Ack !== e1) begin
                n_fail++;
                $display("FAIL tie_ack c%0d: Ack0=%b Ack1=%b, required %b %b", cyc, Req0Ack, Req1Ack, e0, e1);
            end
            if (cyc == 4 * (LAT + 2) - 1) clear_reqs();
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL tie_drain: %0d completions outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_rd_wr();
        Req0Addr    = 16'h0030;
        Req0DataOut = 16'h5555;
        Req0RD      = 1'b1;
        Req0WR      = 1'b1;
        sb.push_back('{id: 1'b0, wr: 1'b1, data: 16'h0000});
        tick();
        n_checks++;
        if (MemWR !== 1'b1 || MemRD !== 1'b0) begin
            n_fail++;
            $display("FAIL rdwr_op: WR=%b RD=%b, required 1 0", MemWR, MemRD);
        end
        for (int c = 2; c <= LAT; c++) tick();
        tick();
        n_checks++;
        if (Req0Ack !== 1'b1 || Req0DataIn !== 16'hA0A0) begin
            n_fail++;
            $display("FAIL rdwr_done: Ack0=%b DataIn=%h, required 1 a0a0", Req0Ack, Req0DataIn);
        end
        clear_reqs();
        tick();
        n_checks++;
        if (dram_val(8'h30) !== 16'h5555 || Req0DataIn !== 16'hA0A0) begin
            n_fail++;
            $display("FAIL rdwr_after: DRAM[0030]=%h DataIn=%h, required 5555 a0a0", dram_val(8'h30), Req0DataIn);
        end
    endtask

    task automatic test_reset_mid_access();
        int   budget;
        Req0Addr = 16'h0040;
        Req0RD   = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        clear_reqs();
        n_checks++;
        if (MemRD !== 1'b0 || Busy !== 1'b0 || Req0Ack !== 1'b0 || Req0DataIn !== '0) begin
            n_fail++;
            $display("FAIL abort: RD=%b Busy=%b Ack0=%b DataIn=%h, required 0 0 0 0000",
                     MemRD, Busy, Req0Ack, Req0DataIn);
        end
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            n_checks++;
            if (Req0Ack !== 1'b0 || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet c%0d: Ack0=%b Busy=%b, required 0 0", c, Req0Ack, Busy);
            end
        end
        Req0Addr = 16'h0050;
        Req1Addr = 16'h0060;
        Req0RD   = 1'b1;
        Req1RD   = 1'b1;
        sb.push_back('{id: 1'b0, wr: 1'b0, data: 16'hA0A0});
        tick();
        n_checks++;
        if (MemAddr !== 16'h0050) begin
            n_fail++;
            $display("FAIL abort_tie: MemAddr=%h, required 0050 (requester 0)", MemAddr);
        end
        budget = 0;
        while (!(Req0Ack || Req1Ack) && budget < 20) begin
            tick();
            budget++;
        end
        n_checks++;
        if (Req0Ack !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_tie_ack: Ack0=%b Ack1=%b after %0d cycles, required Ack0", Req0Ack, Req1Ack, budget);
        end
        clear_reqs();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_tie();
        test_rd_wr();
        test_reset_mid_access();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: %0d completions outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
